// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register, imem valid/ready request FSM and next-PC selection
// (PC+4, branch, jump, jr). Optional macro PC_MISALIGN_TRAP_EN sends misaligned jr
// targets to EXC_VECTOR; without it, jr targets are aligned down to a word boundary.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] fetch_pc,
   output logic        fetch_valid,
   input  logic        fetch_ready,
   input  logic        stall,
   input  logic [31:0] id_pc_plus4,
   input  logic        br_taken,
   input  logic [15:0] br_imm,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jr,
   input  logic [31:0] jr_target,
   output logic [31:0] pc_plus4,
   output logic        redirect,
   output logic        misalign
);
   typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;
   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d, redirect_q, redirect_d, misalign_q, misalign_d;
   logic [31:0] br_target, jump_target, jr_dest;
   logic        jr_bad, redir, accept;
   assign fetch_pc    = pc_q;
   assign fetch_valid = valid_q;
   assign redirect    = redirect_q;
   assign misalign    = misalign_q;
   assign pc_plus4    = pc_q + 32'd4;
`ifdef PC_MISALIGN_TRAP_EN
   assign jr_bad = jr_target[1:0] != 2'b00;
`else
   assign jr_bad = 1'b0;
`endif
   // Redirect targets; jump takes its upper nibble from the decode-stage PC+4
   always_comb begin
      br_target   = id_pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00};
      jump_target = {id_pc_plus4[31:28], jump_index, 2'b00};
      jr_dest     = jr_bad ? EXC_VECTOR : (jr_target & 32'hFFFF_FFFC);
   end
   // Next PC and FSM: redirects beat stall and a pending handshake, jr > jump > branch
   always_comb begin
      redir      = jr | jump | br_taken;
      accept     = valid_q & fetch_ready;
      pc_d       = jr ? jr_dest :
                   jump ? jump_target :
                   br_taken ? br_target :
                   (accept && !stall) ? pc_plus4 : pc_q;
      state_d    = (redir || accept || state_q == BOOT) ? RUN : WAIT;
      valid_d    = 1'b1;
      redirect_d = redir;
      misalign_d = jr & jr_bad;
   end
   // State and registered outputs, synchronous reset abandons any pending request
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         valid_q    <= 1'b0;
         redirect_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         redirect_q <= redirect_d;
         misalign_q <= misalign_d;
      end
   end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic        fetch_ready = 1'b1;
   logic        stall = 1'b0;
   logic [31:0] id_pc_plus4 = '0;
   logic        br_taken = 1'b0;
   logic [15:0] br_imm = '0;
   logic        jump = 1'b0;
   logic [25:0] jump_index = '0;
   logic        jr = 1'b0;
   logic [31:0] jr_target = '0;
   logic [31:0] pc_plus4;
   logic        redirect;
   logic        misalign;

   typedef struct {
      int          idx;
      logic [31:0] pc;
      logic        v;
      logic        r;
      logic        m;
   } exp_t;
   exp_t q[$];
   int pass_cnt = 0;
   int total_cnt = 0;
   int step_no = 0;

`ifdef PC_MISALIGN_TRAP_EN
   localparam logic [31:0] MIS_PC = 32'h0000_0080;
   localparam logic        MIS_M  = 1'b1;
`else
   localparam logic [31:0] MIS_PC = 32'h0000_2000;
   localparam logic        MIS_M  = 1'b0;
`endif

   pc_sequencer dut (
      .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
      .fetch_ready(fetch_ready), .stall(stall), .id_pc_plus4(id_pc_plus4),
      .br_taken(br_taken), .br_imm(br_imm), .jump(jump), .jump_index(jump_index),
      .jr(jr), .jr_target(jr_target), .pc_plus4(pc_plus4), .redirect(redirect),
      .misalign(misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", nm, idx, act, exp);
   endtask

   task automatic step(input logic [31:0] pc, input logic v, input logic r, input logic m);
      exp_t e;
      @(posedge clk);
      #1;
      e.idx = step_no; e.pc = pc; e.v = v; e.r = r; e.m = m;
      q.push_back(e);
      step_no++;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("fetch_pc", e.idx, fetch_pc, e.pc);
            chk("pc_plus4", e.idx, pc_plus4, e.pc + 32'd4);
            chk("fetch_valid", e.idx, {31'd0, fetch_valid}, {31'd0, e.v});
            chk("redirect", e.idx, {31'd0, redirect}, {31'd0, e.r});
            chk("misalign", e.idx, {31'd0, misalign}, {31'd0, e.m});
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin : driver
      step(32'h0, 0, 0, 0);
      step(32'h0, 0, 0, 0);
      rst = 1'b0;
      step(32'h0, 1, 0, 0);
      step(32'h4, 1, 0, 0);
      step(32'h8, 1, 0, 0);
      step(32'hC, 1, 0, 0);
      step(32'h10, 1, 0, 0);
      fetch_ready = 1'b0;
      repeat (3) step(32'h10, 1, 0, 0);
      fetch_ready = 1'b1;
      step(32'h14, 1, 0, 0);
      id_pc_plus4 = 32'h100; br_taken = 1'b1; br_imm = 16'hFFFE;
      step(32'hF8, 1, 1, 0);
      br_imm = 16'h0003;
      step(32'h10C, 1, 1, 0);
      br_taken = 1'b0;
      step(32'h110, 1, 0, 0);
      id_pc_plus4 = 32'hA000_0010; jump = 1'b1; jump_index = 26'h000_0040;
      step(32'hA000_0100, 1, 1, 0);
      jr = 1'b1; jr_target = 32'h2000; br_taken = 1'b1;
      step(32'h2000, 1, 1, 0);
      jr = 1'b0; jump = 1'b0; br_taken = 1'b0;
      step(32'h2004, 1, 0, 0);
      stall = 1'b1;
      step(32'h2004, 1, 0, 0);
      step(32'h2004, 1, 0, 0);
      id_pc_plus4 = 32'h3000_0000; jump = 1'b1; jump_index = 26'h10;
      step(32'h3000_0040, 1, 1, 0);
      stall = 1'b0; jump = 1'b0;
      step(32'h3000_0044, 1, 0, 0);
      fetch_ready = 1'b0;
      step(32'h3000_0044, 1, 0, 0);
      id_pc_plus4 = 32'h200; br_taken = 1'b1; br_imm = 16'h0001;
      step(32'h204, 1, 1, 0);
      br_taken = 1'b0;
      step(32'h204, 1, 0, 0);
      rst = 1'b1;
      step(32'h0, 0, 0, 0);
      rst = 1'b0; fetch_ready = 1'b1;
      step(32'h0, 1, 0, 0);
      step(32'h4, 1, 0, 0);
      jr = 1'b1; jr_target = 32'h2002;
      step(MIS_PC, 1, 1, MIS_M);
      jr = 1'b0;
      step(MIS_PC + 32'd4, 1, 0, 0);
      jr = 1'b1; jr_target = 32'hFFFF_FFFC;
      step(32'hFFFF_FFFC, 1, 1, 0);
      jr = 1'b0;
      step(32'h0, 1, 0, 0);
      step(32'h4, 1, 0, 0);
      repeat (3) @(negedge clk);
      total_cnt++;
      if (q.size() == 0) pass_cnt++;
      else $display("FAIL drain: got %0d pending expected 0", q.size());
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
